logit: RTL and testbench
========================

LOGIT -- requirements
Module: logit

Interface
REQ-001 Parameter DATA_WIDTH, default 16, total fixed-point width of input and output.
REQ-002 Parameter FRAC_BITS, default 10, fractional bits of input and output; INT_BITS = DATA_WIDTH - FRAC_BITS SHALL be >= 4.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_data  input  DATA_WIDTH  signed probability y, Q(INT_BITS).(FRAC_BITS).
REQ-006 i_valid  input  1  i_data valid.
REQ-007 i_ready  output  1  block accepts input this cycle.
REQ-008 o_data  output  DATA_WIDTH  signed logit x, same Q format.
REQ-009 o_valid  output  1  o_data valid.
REQ-010 o_ready  input  1  downstream accepts o_data.

Function
REQ-011 Block SHALL compute the exact inverse of the team's piecewise-quadratic sigmoid (sig(x) = 0.5*(x/4+1)^2 for -4<=x<0, 1-0.5*(1-x/4)^2 for 0<=x<=4).
REQ-012 For y < 0.5: t = 2y, x = 4*sqrt(t) - 4; for y >= 0.5: t = 2*(1-y), x = 4 - 4*sqrt(t).
REQ-013 Saturation: y <= 0 SHALL give x = -4.0; y >= 1.0 SHALL give x = +4.0; the sqrt result is overridden, latency unchanged.
REQ-014 sqrt(t) SHALL be floor(isqrt(t << FRAC_BITS)), radicand 2*FRAC_BITS+1 bits, root FRAC_BITS+1 bits, computed bit-serially, one root bit per clock, MSB first.
REQ-015 Final scale/offset SHALL be done in DATA_WIDTH+1 bits with no overflow; result truncated to DATA_WIDTH exactly (range is within +-4.0).
REQ-016 FSM states: IDLE, CALC, DONE.
REQ-017 IDLE: i_ready=1; on i_valid&&i_ready capture t, half-select, saturation flags; go to CALC, iteration counter = FRAC_BITS.
REQ-018 CALC: i_ready=0; one root bit per cycle; counter decrements; after counter==0 iteration go to DONE and register o_data.
REQ-019 Latency: o_valid SHALL rise exactly FRAC_BITS+1 clock edges after the accepting edge (11 for defaults).
REQ-020 DONE: o_valid=1, i_ready=0; o_data SHALL remain stable until o_valid&&o_ready; on that edge go to IDLE, o_valid=0.
REQ-021 One transaction in flight; i_valid while i_ready=0 SHALL be ignored (not captured).
REQ-022 o_data SHALL hold last result after handshake until next DONE.

Reset
REQ-023 Asserting rst_n low, at any state including mid-CALC, SHALL immediately force state=IDLE, o_valid=0, o_data=0, counter=0; in-flight transaction discarded.
REQ-024 i_ready SHALL be 1 from the first cycle after rst_n deasserts.
REQ-025 Datapath registers other than o_data need no reset.

Structure
REQ-026 Fixed-point constants (ONE, HALF, FOUR, MINUS_FOUR, derived from DATA_WIDTH/FRAC_BITS) and FSM state encodings SHALL live in the shared fixed-point package/header used by the activation blocks.
REQ-027 Bit-serial square root SHALL be a sub-module isqrt_seq (start/busy/done, radicand in, root out); logit holds FSM, pre/post arithmetic, handshake.

Verification
REQ-028 y=512 (0.5) -> o_data=0x0000, o_valid 11 cycles after accept.
REQ-029 y=128 (0.125) -> 0xF800 (-2.0); y=896 (0.875) -> 0x0800 (+2.0).
REQ-030 y=0, y=-300, y=1024, y=2000 -> 0xF000, 0xF000, 0x1000, 0x1000 at same latency.
REQ-031 o_ready low 5 cycles in DONE -> o_data/o_valid stable, i_ready=0, second i_valid not captured; o_ready high -> IDLE next cycle.
REQ-032 rst_n pulsed low in 4th CALC cycle -> o_valid=0, o_data=0, i_ready=1 after release, no spurious output.
REQ-033 Sweep y=0..1024 through sigmoid then logit model -> round-trip error within 4 LSB for |x|<3.5.

Source files
------------

// File: rtl/logit_pkg.sv
// Shared fixed-point helpers for the activation blocks: Q-format constants and
// the handshake FSM state encoding.
package logit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } fx_state_e;

    function automatic int fx_one(input int frac_bits);
        return 1 << frac_bits;
    endfunction

    function automatic int fx_half(input int frac_bits);
        return 1 << (frac_bits - 1);
    endfunction

    function automatic int fx_four(input int frac_bits);
        return 4 << frac_bits;
    endfunction

    function automatic int fx_minus_four(input int frac_bits);
        return -(4 << frac_bits);
    endfunction

endpackage

// File: rtl/isqrt_seq.sv
// Bit-serial integer square root, one root bit per clock, MSB first.
// `root` carries the current step's decision, so it is the final root while `done` is high.
module isqrt_seq #(
    parameter int ROOT_W = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2*ROOT_W-2:0]   radicand,
    output logic                  busy,
    output logic                  done,
    output logic [ROOT_W-1:0]     root
);

    localparam int RAD_W = 2 * ROOT_W - 1;
    localparam int SQ_W  = 2 * ROOT_W;
    localparam int CNT_W = $clog2(ROOT_W);

    logic              busy_reg;
    logic [CNT_W-1:0]  bit_reg;
    logic [RAD_W-1:0]  rad_reg;
    logic [ROOT_W-1:0] root_reg;
    logic [ROOT_W-1:0] trial;
    logic [SQ_W-1:0]   trial_sq;
    logic [ROOT_W-1:0] root_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= 1'b0;
            bit_reg  <= '0;
        end else if (start) begin
            busy_reg <= 1'b1;
            bit_reg  <= CNT_W'(ROOT_W - 1);
        end else if (busy_reg) begin
            if (bit_reg == '0) begin
                busy_reg <= 1'b0;
            end else begin
                bit_reg <= bit_reg - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            rad_reg  <= radicand;
            root_reg <= '0;
        end else if (busy_reg) begin
            root_reg <= root_next;
        end
    end

    // Keep the trial bit only if its square still fits under the radicand.
    always_comb begin
        trial     = root_reg | (ROOT_W'(1) << bit_reg);
        trial_sq  = SQ_W'(trial) * SQ_W'(trial);
        root_next = (trial_sq <= SQ_W'(rad_reg)) ? trial : root_reg;
    end

    assign busy = busy_reg;
    assign done = busy_reg && (bit_reg == '0);
    assign root = root_next;

endmodule

// File: rtl/logit.sv
// Inverse of the piecewise-quadratic sigmoid: x = +-(4*sqrt(t) - 4), with
// t = 2y or 2(1-y) depending on which half of the curve y falls in.
module logit
    import logit_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  o_ready
);

    localparam int EXT_W  = DATA_WIDTH + 1;
    localparam int ROOT_W = FRAC_BITS + 1;
    localparam int RAD_W  = 2 * FRAC_BITS + 1;
    localparam int CNT_W  = $clog2(ROOT_W);

    localparam logic signed [EXT_W-1:0] ONE        = EXT_W'(fx_one(FRAC_BITS));
    localparam logic signed [EXT_W-1:0] HALF       = EXT_W'(fx_half(FRAC_BITS));
    localparam logic signed [EXT_W-1:0] FOUR       = EXT_W'(fx_four(FRAC_BITS));
    localparam logic signed [EXT_W-1:0] MINUS_FOUR = EXT_W'(fx_minus_four(FRAC_BITS));

    fx_state_e             state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [DATA_WIDTH-1:0] o_data_reg, o_data_next;

    logic                  upper_reg, sat_lo_reg, sat_hi_reg;

    logic signed [EXT_W-1:0] y_ext;
    logic                    in_upper, in_sat_lo, in_sat_hi;
    logic [ROOT_W-1:0]       t_val;
    logic [RAD_W-1:0]        radicand;

    logic                    sqrt_start, sqrt_busy, sqrt_done;
    logic [ROOT_W-1:0]       sqrt_root;
    logic signed [EXT_W-1:0] scaled;
    logic [DATA_WIDTH-1:0]   result;

    // Out-of-range t values under saturation are harmless: the result is overridden.
    always_comb begin
        y_ext     = {i_data[DATA_WIDTH-1], i_data};
        in_sat_lo = i_data[DATA_WIDTH-1] || (i_data == '0);
        in_sat_hi = (y_ext >= ONE);
        in_upper  = (y_ext >= HALF);
        t_val     = in_upper ? ROOT_W'((ONE - y_ext) <<< 1) : ROOT_W'(y_ext <<< 1);
        radicand  = {t_val, {FRAC_BITS{1'b0}}};
    end

    always_ff @(posedge clk) begin
        if (sqrt_start) begin
            upper_reg  <= in_upper;
            sat_lo_reg <= in_sat_lo;
            sat_hi_reg <= in_sat_hi;
        end
    end

    isqrt_seq #(
        .ROOT_W (ROOT_W)
    ) u_isqrt (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (sqrt_start),
        .radicand (radicand),
        .busy     (sqrt_busy),
        .done     (sqrt_done),
        .root     (sqrt_root)
    );

    // Root is Q.FRAC_BITS in [0,1], so 4*root stays inside the widened range.
    always_comb begin
        scaled = EXT_W'(sqrt_root) << 2;
        if (sat_lo_reg) begin
            result = DATA_WIDTH'(MINUS_FOUR);
        end else if (sat_hi_reg) begin
            result = DATA_WIDTH'(FOUR);
        end else if (upper_reg) begin
            result = DATA_WIDTH'(FOUR - scaled);
        end else begin
            result = DATA_WIDTH'(scaled - FOUR);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            o_data_reg <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            o_data_reg <= o_data_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        o_data_next = o_data_reg;
        sqrt_start  = 1'b0;
        i_ready     = 1'b0;
        o_valid     = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                i_ready = 1'b1;
                if (i_valid) begin
                    sqrt_start = 1'b1;
                    state_next = ST_CALC;
                    cnt_next   = CNT_W'(FRAC_BITS);
                end
            end
            ST_CALC: begin
                // sqrt_done coincides with the counter==0 iteration.
                if (sqrt_done) begin
                    state_next  = ST_DONE;
                    cnt_next    = '0;
                    o_data_next = result;
                end else if (!sqrt_busy) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ST_DONE: begin
                o_valid = 1'b1;
                if (o_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign o_data = o_data_reg;

endmodule

// File: tb/tb_logit.sv
// Self-checking bench for logit: directed points, saturation, back-pressure,
// mid-computation reset, random values and a full round-trip sweep.
module tb_logit;

    localparam int LAT = 11;

    logic        clk;
    logic        rst_n;
    logic [15:0] i_data;
    logic        i_valid;
    logic        i_ready;
    logic [15:0] o_data;
    logic        o_valid;
    logic        o_ready;

    int checks;
    int failures;

    logit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_data  (i_data),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_ready (o_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: inverse sigmoid from its definition, exact integer floor sqrt.
    function automatic logic [15:0] model_logit(input int y);
        int     t;
        int     r;
        longint v;
        if (y <= 0) return 16'hF000;
        if (y >= 1024) return 16'h1000;
        t = (y < 512) ? 2 * y : 2 * (1024 - y);
        v = longint'(t) * 1024;
        r = int'($floor($sqrt(real'(v))));
        while (longint'(r) * r > v) r--;
        while (longint'(r + 1) * (r + 1) <= v) r++;
        return (y < 512) ? 16'(4 * r - 4096) : 16'(4096 - 4 * r);
    endfunction

    function automatic real model_sigmoid(input real x);
        if (x < 0.0) return 0.5 * (x / 4.0 + 1.0) * (x / 4.0 + 1.0);
        return 1.0 - 0.5 * (1.0 - x / 4.0) * (1.0 - x / 4.0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at #1 after a rising edge; returns with o_valid seen (or budget spent).
    task automatic do_txn(input int y, output logic [15:0] got, output int lat);
        int guard;
        guard = 0;
        while (!i_ready && guard < 50) begin
            step();
            guard++;
        end
        i_data  = 16'(y);
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        i_data  = 16'($urandom);
        lat = 0;
        while (!o_valid && lat < 40) begin
            step();
            lat++;
        end
        got = o_data;
        $display("txn y=%0d x=0x%04h latency=%0d", y, got, lat);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_data  = 16'h0000;
        o_ready = 1'b1;
        repeat (3) step();
        checks++;
        if (o_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_o_valid: got %b expected 0", o_valid);
        end
        checks++;
        if (o_data !== 16'h0000) begin
            failures++;
            $display("FAIL reset_o_data: got %h expected 0000", o_data);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (i_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_i_ready: got %b expected 1", i_ready);
        end
    endtask

    task automatic test_directed();
        int          ys[7]   = '{512, 128, 896, 0, -300, 1024, 2000};
        logic [15:0] exps[7] = '{16'h0000, 16'hF800, 16'h0800, 16'hF000,
                                 16'hF000, 16'h1000, 16'h1000};
        logic [15:0] got;
        int          lat;
        o_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            do_txn(ys[i], got, lat);
            checks++;
            if (got !== exps[i]) begin
                failures++;
                $display("FAIL directed_data y=%0d: got %h expected %h", ys[i], got, exps[i]);
            end
            checks++;
            if (lat != LAT) begin
                failures++;
                $display("FAIL directed_latency y=%0d: got %0d expected %0d", ys[i], lat, LAT);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] got;
        logic [15:0] held;
        int          lat;
        bit          spurious;
        o_ready = 1'b0;
        do_txn(300, got, lat);
        held = got;
        checks++;
        if (held !== model_logit(300)) begin
            failures++;
            $display("FAIL bp_data: got %h expected %h", held, model_logit(300));
        end
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                i_data  = 16'd700;
                i_valid = 1'b1;
            end
            step();
            checks++;
            if (o_valid !== 1'b1 || o_data !== held || i_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cycle %0d: got valid=%b data=%h ready=%b expected valid=1 data=%h ready=0",
                         k, o_valid, o_data, i_ready, held);
            end
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        step();
        checks++;
        if (o_valid !== 1'b0 || i_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: got valid=%b ready=%b expected valid=0 ready=1", o_valid, i_ready);
        end
        checks++;
        if (o_data !== held) begin
            failures++;
            $display("FAIL bp_data_retained: got %h expected %h", o_data, held);
        end
        spurious = 1'b0;
        repeat (15) begin
            step();
            if (o_valid) spurious = 1'b1;
        end
        checks++;
        if (spurious !== 1'b0) begin
            failures++;
            $display("FAIL bp_ignored_input: got o_valid pulse expected none");
        end
    endtask

    task automatic test_reset_mid_calc();
        logic [15:0] got;
        int          lat;
        bit          spurious;
        o_ready = 1'b1;
        do_txn(128, got, lat);
        step();
        checks++;
        if (o_data !== 16'hF800) begin
            failures++;
            $display("FAIL midrst_pre: got %h expected F800", o_data);
        end
        i_data  = 16'd300;
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_data !== 16'h0000) begin
            failures++;
            $display("FAIL midrst_async: got valid=%b data=%h expected valid=0 data=0000", o_valid, o_data);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (i_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_i_ready: got %b expected 1", i_ready);
        end
        spurious = 1'b0;
        repeat (20) begin
            step();
            if (o_valid || o_data !== 16'h0000) spurious = 1'b1;
        end
        checks++;
        if (spurious !== 1'b0) begin
            failures++;
            $display("FAIL midrst_spurious: got output activity expected none");
        end
    endtask

    task automatic test_random();
        logic [15:0] got;
        logic [15:0] held;
        int          lat;
        int          y;
        int          stall;
        for (int n = 0; n < 60; n++) begin
            if (n % 10 == 9) y = int'($signed(16'($urandom)));
            else y = int'($urandom_range(1500, 0)) - 200;
            stall   = int'($urandom_range(3, 0));
            o_ready = (stall == 0);
            do_txn(y, got, lat);
            checks++;
            if (got !== model_logit(y) || lat != LAT) begin
                failures++;
                $display("FAIL random y=%0d: got %h latency %0d expected %h latency %0d",
                         y, got, lat, model_logit(y), LAT);
            end
            held = got;
            if (stall != 0) begin
                repeat (stall) step();
                checks++;
                if (o_valid !== 1'b1 || o_data !== held) begin
                    failures++;
                    $display("FAIL random_stall y=%0d: got valid=%b data=%h expected valid=1 data=%h",
                             y, o_valid, o_data, held);
                end
                o_ready = 1'b1;
            end
            step();
        end
    endtask

    task automatic test_sweep();
        logic [15:0] got;
        int          lat;
        int          x;
        real         y_back;
        real         err;
        o_ready = 1'b1;
        for (int y = 0; y <= 1024; y++) begin
            do_txn(y, got, lat);
            checks++;
            if (got !== model_logit(y)) begin
                failures++;
                $display("FAIL sweep_data y=%0d: got %h expected %h", y, got, model_logit(y));
            end
            x = int'($signed(got));
            if (x > -3584 && x < 3584) begin
                y_back = model_sigmoid(real'(x) / 1024.0) * 1024.0;
                err    = y_back - real'(y);
                if (err < 0.0) err = -err;
                checks++;
                if (err > 4.0) begin
                    failures++;
                    $display("FAIL sweep_roundtrip y=%0d: got sigmoid(x)=%f expected within 4 of %0d",
                             y, y_back, y);
                end
            end
            step();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        i_valid  = 1'b0;
        i_data   = 16'h0000;
        o_ready  = 1'b1;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_calc();
        test_random();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
